// File: rtl/fir_feeder.sv
// Host-side front end for the FIR controller: buffers samples, holds one coefficient,
// and sequences the lc/dr handshakes. Define FIR_FEEDER_WATCHDOG_EN to add the wait watchdog.
module fir_feeder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [DATA_W-1:0]             sample_data,
    output logic                          sample_ready,
    input  logic                          coeff_valid,
    input  logic [DATA_W-1:0]             coeff_data,
    output logic                          coeff_ready,
    input  logic                          modwait,
    input  logic                          err,
    output logic                          dr,
    output logic                          lc,
    output logic [DATA_W-1:0]             sample_out,
    output logic [DATA_W-1:0]             fir_coeff,
    output logic [1:0]                    coeff_idx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          sample_err,
    output logic                          timeout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LC, S_C_HI, S_C_LO, S_DR1, S_DR2, S_BUSY
    } state_t;

    state_t                           state;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
    logic [PW-1:0]                    wr_ptr, rd_ptr;
    logic [CW-1:0]                    count;
    logic                             full, empty, push, pop;
    logic [DATA_W-1:0]                coeff_reg;
    logic                             coeff_full, coeff_take, coeff_free;
    logic [1:0]                       idx;
    logic                             locked, seen_hi, sample_done, wd_fire;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign push        = sample_valid && !full;
    assign locked      = (idx != 2'd0);
    // Error-idle (err with modwait low) completes a sample even if modwait never rose.
    assign sample_done = (state == S_BUSY) && !modwait && (seen_hi || err);
    assign pop         = sample_done || ((state == S_BUSY) && wd_fire);
    assign coeff_take  = coeff_valid && !coeff_full;
    assign coeff_free  = ((state == S_C_LO) && !modwait) || (wd_fire && (state != S_BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coeff_reg  <= '0;
            coeff_full <= 1'b0;
        end else if (coeff_take) begin
            coeff_reg  <= coeff_data;
            coeff_full <= 1'b1;
        end else if (coeff_free) begin
            coeff_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            seen_hi    <= 1'b0;
            sample_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (coeff_full)
                        state <= S_LC;
                    else if (!empty && !locked)
                        state <= S_DR1;
                end
                S_LC:   state <= S_C_HI;
                S_C_HI: begin
                    if (wd_fire) begin
                        state <= S_IDLE;
                        idx   <= 2'd0;
                    end else if (modwait) begin
                        state <= S_C_LO;
                    end
                end
                S_C_LO: begin
                    if (wd_fire) begin
                        state <= S_IDLE;
                        idx   <= 2'd0;
                    end else if (!modwait) begin
                        state <= S_IDLE;
                        idx   <= idx + 1'b1;
                    end
                end
                S_DR1:  state <= S_DR2;
                S_DR2: begin
                    seen_hi <= modwait;
                    state   <= S_BUSY;
                end
                S_BUSY: begin
                    if (modwait)
                        seen_hi <= 1'b1;
                    if (sample_done) begin
                        state <= S_IDLE;
                        if (err)
                            sample_err <= 1'b1;
                    end else if (wd_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FIR_FEEDER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_cnt;
    logic          waiting, advance;

    assign waiting = (state == S_C_HI) || (state == S_C_LO) || (state == S_BUSY);

    always_comb begin
        advance = 1'b0;
        case (state)
            S_C_HI:  advance = modwait;
            S_C_LO:  advance = !modwait;
            S_BUSY:  advance = sample_done;
            default: advance = 1'b0;
        endcase
    end

    // Fires on the TIMEOUT-th cycle in a wait state unless the wait resolves that cycle.
    assign wd_fire = waiting && !advance && (wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (!waiting || advance || wd_fire)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire)
                timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    // Always 0 here; TIMEOUT only matters when the watchdog is built in.
    assign timeout = (TIMEOUT < 0);
`endif

    assign sample_ready = !full;
    assign coeff_ready  = !coeff_full;
    assign dr           = (state == S_DR1) || (state == S_DR2);
    assign lc           = (state == S_LC);
    assign busy         = (state != S_IDLE);
    assign sample_out   = mem[rd_ptr];
    assign fir_coeff    = coeff_reg;
    assign coeff_idx    = idx;
    assign fifo_count   = count;

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder: a controller model answers lc/dr, and queues of
// expected coefficients/samples are checked as the DUT issues them.
module tb_fir_feeder;

    localparam int M_NORMAL = 0;
    localparam int M_STUCK  = 1;
    localparam int M_NEVER  = 2;
    localparam int M_ERR    = 3;
    localparam byte EV_C    = 8'h43;
    localparam byte EV_S    = 8'h53;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid, coeff_valid;
    logic [15:0] sample_data, coeff_data;
    logic        sample_ready, coeff_ready;
    logic        modwait, err;
    logic        dr, lc, busy, sample_err, timeout;
    logic [15:0] sample_out, fir_coeff;
    logic [1:0]  coeff_idx;
    logic [2:0]  fifo_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cq[$];
    logic [15:0] sq[$];
    byte         ev[$];
    logic [15:0] cur_s;
    logic        prev_dr, prev2_dr, prev_lc;
    int          mode, dr_hold, mw_cnt, err_cnt;

    fir_feeder #(.DATA_W(16), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
        .modwait(modwait), .err(err), .dr(dr), .lc(lc),
        .sample_out(sample_out), .fir_coeff(fir_coeff), .coeff_idx(coeff_idx),
        .fifo_count(fifo_count), .busy(busy), .sample_err(sample_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: checks issued handshakes against the queues, then the controller reacts.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            prev_dr = 0; prev2_dr = 0; prev_lc = 0;
            modwait = 0; err = 0; mw_cnt = 0; err_cnt = 0;
            return;
        end
        if (lc) begin
            chk("lc_width", prev_lc, 0);
            if (cq.size() == 0) chk("lc_extra", 1, 0);
            else chk("lc_coeff", fir_coeff, cq.pop_front());
            ev.push_back(EV_C);
        end
        if (dr && !prev_dr) begin
            chk("dr_lock", coeff_idx, 0);
            if (sq.size() == 0) chk("dr_extra", 1, 0);
            else begin
                cur_s = sq.pop_front();
                chk("dr_data", sample_out, cur_s);
            end
            ev.push_back(EV_S);
        end
        if (dr && prev_dr) begin
            chk("dr_hold", sample_out, cur_s);
            chk("dr_width", prev2_dr, 0);
        end
        if (!dr && prev_dr) chk("dr_len", prev2_dr, 1);
        if (mw_cnt > 0) begin
            mw_cnt--;
            if (mw_cnt == 0) modwait = 0;
        end
        if (err_cnt > 0) begin
            err_cnt--;
            if (err_cnt == 0) err = 0;
        end
        if (lc && mode != M_NEVER) begin
            modwait = 1; mw_cnt = 2;
        end
        if (dr && !prev_dr) begin
            case (mode)
                M_NORMAL: begin modwait = 1; mw_cnt = dr_hold; end
                M_STUCK:  begin modwait = 1; mw_cnt = 1000000; end
                M_ERR:    begin err = 1; err_cnt = 3; end
                default:  ;
            endcase
        end
        prev2_dr = prev_dr; prev_dr = dr; prev_lc = lc;
    endtask

    task automatic push_coeff(input logic [15:0] v);
        int n = 0;
        while (!coeff_ready && n < 200) begin step(); n++; end
        chk("coeff_rdy_wait", coeff_ready, 1);
        coeff_valid = 1; coeff_data = v; cq.push_back(v);
        step();
        coeff_valid = 0;
    endtask

    task automatic push_sample(input logic [15:0] v);
        int n = 0;
        while (!sample_ready && n < 200) begin step(); n++; end
        chk("sample_rdy_wait", sample_ready, 1);
        sample_valid = 1; sample_data = v; sq.push_back(v);
        step();
        sample_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fifo_count != 0 || !coeff_ready) && n < 400) begin step(); n++; end
        chk("idle_wait", !busy && fifo_count == 0 && coeff_ready, 1);
    endtask

    task automatic wait_dr();
        int n = 0;
        while (!dr && n < 50) begin step(); n++; end
        chk("dr_wait", dr, 1);
    endtask

    task automatic check_reset_state();
        chk("rst_sready", sample_ready, 1);
        chk("rst_cready", coeff_ready, 1);
        chk("rst_dr", dr, 0);
        chk("rst_lc", lc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_idx", coeff_idx, 0);
        chk("rst_sout", sample_out, 0);
        chk("rst_coeff", fir_coeff, 0);
        chk("rst_serr", sample_err, 0);
        chk("rst_timeout", timeout, 0);
    endtask

    initial begin
        logic [39:0] evp;
        logic [39:0] ev_exp;
        int n;
        rst = 1; sample_valid = 0; coeff_valid = 0; sample_data = 0; coeff_data = 0;
        modwait = 0; err = 0; mode = M_NORMAL; dr_hold = 3; mw_cnt = 0; err_cnt = 0;
        prev_dr = 0; prev2_dr = 0; prev_lc = 0; cur_s = 0;
        step(); step();
        check_reset_state();
        rst = 0;
        step();

        // Coefficient burst 1..4; the first one timed cycle by cycle.
        ev.delete();
        coeff_valid = 1; coeff_data = 16'h0001; cq.push_back(16'h0001);
        step();
        coeff_valid = 0;
        chk("c1_lc_n1", lc, 0);
        chk("c1_cready_n1", coeff_ready, 0);
        step(); chk("c1_lc_n2", lc, 1);
        step(); chk("c1_lc_n3", lc, 0); chk("c1_cready_chi", coeff_ready, 0);
        step(); chk("c1_cready_clo", coeff_ready, 0);
        step(); chk("c1_cready_back", coeff_ready, 1); chk("c1_idx", coeff_idx, 1);
        for (int i = 2; i <= 4; i++) push_coeff(16'(i));
        wait_idle();
        chk("burst_idx_wrap", coeff_idx, 0);
        chk("burst_last_coeff", fir_coeff, 16'h0004);
        chk("burst_lc_count", ev.size(), 4);
        chk("burst_cq_empty", cq.size(), 0);

        // Single sample with a 20-cycle busy controller.
        ev.delete();
        dr_hold = 21;
        sample_valid = 1; sample_data = 16'h1234; sq.push_back(16'h1234);
        step();
        sample_valid = 0;
        chk("s1_dr_n1", dr, 0);
        chk("s1_count_n1", fifo_count, 1);
        step(); chk("s1_dr_n2", dr, 1); chk("s1_sout_n2", sample_out, 16'h1234);
        step(); chk("s1_dr_n3", dr, 1);
        step(); chk("s1_dr_n4", dr, 0); chk("s1_busy_n4", busy, 1);
        chk("s1_sout_busy", sample_out, 16'h1234);
        for (int k = 5; k <= 23; k++) step();
        chk("s1_count_hold", fifo_count, 1);
        chk("s1_busy_hold", busy, 1);
        step();
        chk("s1_count_pop", fifo_count, 0);
        chk("s1_busy_done", busy, 0);

        // Overfill with the controller stuck busy.
        ev.delete();
        mode = M_STUCK; dr_hold = 3;
        for (int i = 0; i < 5; i++) begin
            chk("fill_ready", sample_ready, (i < 4) ? 1 : 0);
            sample_valid = 1; sample_data = 16'hA0 + 16'(i);
            if (i < 4) sq.push_back(16'hA0 + 16'(i));
            step();
        end
        sample_valid = 0;
        chk("fill_count", fifo_count, 4);
        chk("fill_sready", sample_ready, 0);
        step(); step(); step();
        chk("fill_count_stuck", fifo_count, 4);
        mode = M_NORMAL; mw_cnt = 0; modwait = 0;
        wait_idle();
        chk("fill_sq_drained", sq.size(), 0);
        chk("fill_issued", ev.size(), 4);

        // Sample and coefficient together: coefficient first, samples held by the burst lock.
        ev.delete();
        sample_valid = 1; sample_data = 16'h5555; sq.push_back(16'h5555);
        coeff_valid = 1; coeff_data = 16'h0011; cq.push_back(16'h0011);
        step();
        sample_valid = 0; coeff_valid = 0;
        push_coeff(16'h0022);
        n = 0;
        while (!coeff_ready && n < 50) begin step(); n++; end
        for (int k = 0; k < 10; k++) step();
        chk("lock_events", ev.size(), 2);
        chk("lock_idx", coeff_idx, 2);
        chk("lock_count", fifo_count, 1);
        chk("lock_dr", dr, 0);
        push_coeff(16'h0033);
        push_coeff(16'h0044);
        wait_idle();
        chk("order_len", ev.size(), 5);
        evp = '0;
        foreach (ev[i]) evp = {evp[31:0], ev[i]};
        ev_exp = {EV_C, EV_C, EV_C, EV_C, EV_S};
        chk("order", evp, ev_exp);

        // Controller error-idle completes the sample and latches sample_err.
        chk("serr_clear", sample_err, 0);
        mode = M_ERR;
        push_sample(16'h0E0E);
        wait_idle();
        chk("serr_set", sample_err, 1);
        chk("serr_popped", fifo_count, 0);
        mode = M_NORMAL; dr_hold = 3;
        push_sample(16'h0F0F);
        wait_idle();
        chk("serr_sticky", sample_err, 1);
        chk("serr_next_issued", sq.size(), 0);

`ifdef FIR_FEEDER_WATCHDOG_EN
        mode = M_NEVER;
        push_sample(16'h0B0B);
        wait_dr();
        step(); step();
        chk("wd_busy_entry", busy && !dr, 1);
        for (int j = 1; j <= 63; j++) step();
        chk("wd_pre_timeout", timeout, 0);
        chk("wd_pre_busy", busy, 1);
        step();
        chk("wd_timeout", timeout, 1);
        chk("wd_idle", busy, 0);
        chk("wd_popped", fifo_count, 0);
`endif

        // Reset while BUSY with a coefficient also pending.
        mode = M_NEVER;
        push_sample(16'h7777);
        wait_dr();
        step(); step();
        coeff_valid = 1; coeff_data = 16'h0C0C;
        step();
        coeff_valid = 0;
        chk("mid_busy", busy, 1);
        chk("mid_count", fifo_count, 1);
        chk("mid_cpending", coeff_ready, 0);
        #2 rst = 1;
        #1 check_reset_state();
        step(); step();
        rst = 0;
        step(); step();
        chk("post_rst_lc", lc, 0);
        chk("post_rst_busy", busy, 0);
        mode = M_NORMAL; dr_hold = 3;
        push_sample(16'h4242);
        wait_idle();
        chk("end_sq_empty", sq.size(), 0);
        chk("end_cq_empty", cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_feeder.md
# fir_feeder

- Sits directly upstream of the FIR filter controller and decouples the host side from the controller's `dr`/`lc`/`modwait` handshake.
- Buffers incoming samples in a small FIFO and holds one pending coefficient.
- Issues each coefficient as a one-cycle `lc` pulse and each sample as a two-cycle `dr` pulse, then waits for the controller to finish before issuing the next.
- Coefficient bursts have priority; samples are blocked until a 4-coefficient set is complete.

## Interface
Parameters:
- DATA_W, 16, sample/coefficient width
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, ≥2)
- TIMEOUT, 64, watchdog limit in cycles (used only with `FIR_FEEDER_WATCHDOG_EN`)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- sample_valid  in  1  host sample offered
- sample_data  in  DATA_W  host sample
- sample_ready  out  1  FIFO not full
- coeff_valid  in  1  host coefficient offered
- coeff_data  in  DATA_W  host coefficient
- coeff_ready  out  1  coefficient register empty
- modwait  in  1  controller busy flag
- err  in  1  controller error flag
- dr  out  1  data ready to controller
- lc  out  1  load coefficient to controller
- sample_out  out  DATA_W  FIFO head; stable from DR1 through BUSY
- fir_coeff  out  DATA_W  coefficient register; stable from LC through WAIT_LO
- coeff_idx  out  2  index (0..3) of the coefficient being or next to be loaded
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- busy  out  1  state ≠ IDLE
- sample_err  out  1  sticky; set when `err`=1 at completion of a sample
- timeout  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out

## Operation
- Host handshakes:
  - Push when `sample_valid & sample_ready`; `sample_ready = !full`, from registered count.
  - A push while full is ignored, even if a pop occurs the same cycle.
  - Push and pop in the same cycle (not full) leave the count unchanged.
  - Coefficient captured when `coeff_valid & coeff_ready`.
- Burst lock: set when `coeff_idx`≠0. While locked, no `dr` is issued.
- IDLE:
  - If a coefficient is pending, go to LC.
  - Else if the FIFO is non-empty and the burst is not locked, go to DR1.
  - Else stay in IDLE.
  - A coefficient wins when both a coefficient and a sample are available.
- LC: `lc`=1 → C_HI.
- C_HI: wait for `modwait`=1 → C_LO.
- C_LO: wait for `modwait`=0 → free the coefficient register, `coeff_idx`+1 (wraps 3→0) → IDLE.
- DR1: `dr`=1 → DR2.
- DR2: `dr`=1 → BUSY.
- BUSY:
  - Wait for `modwait`=0 while having seen `modwait`=1 at least once since DR2.
  - Then pop the FIFO; if `err`=1 set `sample_err` → IDLE.
  - `err`=1 with `modwait`=0 also completes the sample (controller error-idle).
- `dr`, `lc`, and `busy` are decoded from registered state (Moore); no glitches.
- Reset, including mid-operation: state IDLE, FIFO empty, count 0, `coeff_idx` 0, coefficient register empty.
  - All outputs are 0 except `sample_ready`=1 and `coeff_ready`=1.
  - `sample_out` and `fir_coeff` are 0.
  - Sticky flags are cleared.

## Timing
- Sample accepted at edge N, block idle and unlocked: `dr` high in cycles N+2 and N+3.
- Coefficient accepted at edge N, block idle: `lc` high in cycle N+2 only.
- Minimum `lc`-to-`lc` spacing: 4 cycles (LC, C_HI, C_LO, IDLE).
- `coeff_ready` rises in the cycle after C_LO completes.
- FIFO pop and count decrement at the BUSY exit edge; the new head is visible the next cycle.

## Configuration
- `FIR_FEEDER_WATCHDOG_EN` defined:
  - A cycle counter runs in C_HI, C_LO, and BUSY, and clears on every state change.
  - On reaching TIMEOUT, go to IDLE and set `timeout`.
  - In BUSY, pop the sample.
  - In C_HI/C_LO, drop the coefficient and reset `coeff_idx` to 0.
- Undefined: no counter; waits are unbounded; `timeout` is tied to 0.

## Test plan
- Reset then 4 coefficients 0x0001..0x0004 with modwait modeled 1-cycle high after each `lc` → 4 single-cycle `lc` pulses, `fir_coeff` 1,2,3,4, `coeff_idx` ends at 0.
- Sample 0x1234 pushed at edge N, model holds `modwait` high 20 cycles from N+3 → `dr` high in N+2 and N+3, `sample_out`=0x1234 throughout, pop after `modwait` falls.
- Push FIFO_DEPTH+1 samples back-to-back with `modwait` stuck high → `sample_ready`=0 after the 4th, 5th ignored, `fifo_count`=4.
- Sample and coefficient offered in the same cycle from IDLE → `lc` precedes `dr`; after 2 coefficients, `dr` stays low until coefficients 3 and 4 complete.
- Controller returns `err`=1, `modwait`=0 in BUSY → sample popped, `sample_err`=1 and held; next sample still issued.
- With `FIR_FEEDER_WATCHDOG_EN`, TIMEOUT=64, `modwait` never rises after `dr` → `timeout`=1 64 cycles after BUSY entry, FIFO popped, state IDLE; assert `rst` mid-BUSY → all outputs reset values within the same cycle.
